// File: rtl/config_loader_pkg.sv
// config_loader_pkg: loader state encoding and CRC-8 constants shared by the
// configuration loader and its optional CRC checker.
package config_loader_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, CHECK, DONE, ERROR} state_e;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
endpackage

// File: rtl/config_crc8.sv
// config_crc8: bit-serial CRC-8 with an MSB-first register, consuming one chain
// bit per cycle in shift order.
module config_crc8
  import config_loader_pkg::*;
(
  input  logic       clock_i,
  input  logic       nreset_i,
  input  logic       clear_i,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);
  logic [7:0] crc_q, crc_d;
  logic       fb;
  always_comb begin
    fb    = crc_q[7] ^ bit_i;
    crc_d = clear_i ? CRC8_INIT
          : bit_valid_i ? ({crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00)) : crc_q;
  end
  always_ff @(posedge clock_i)
    if (!nreset_i) crc_q <= CRC8_INIT;
    else           crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/config_loader.sv
// config_loader: clears the tile configuration chain, serialises host words into it
// LSB-first, then releases the fabric. CONFIG_LOADER_CRC_EN adds a trailing CRC-8 check.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LENGTH = 146,
  parameter int WORD_WIDTH   = 8,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock_i,
  input  logic                  nreset_i,
  input  logic                  start_i,
  input  logic [WORD_WIDTH-1:0] word_data_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic                  config_out_o,
  output logic                  config_enable_o,
  output logic                  config_nreset_o,
  output logic                  fabric_nreset_o,
  output logic                  fabric_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);
  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int IW = $clog2(WORD_WIDTH + 1);
  localparam int KW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LENGTH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_WIDTH - 1);
  localparam logic [KW-1:0] CLR_LAST = KW'(CLEAR_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [KW-1:0]           clr_q, clr_d;
  logic [WORD_WIDTH-1:0]   sh_q, sh_d;
  logic                    config_nreset_q, config_nreset_d;
  logic                    fabric_nreset_q, fabric_nreset_d;
  logic                    fabric_enable_q, fabric_enable_d;
  logic                    xfer, chain_full, last_bit, crc_ok;

  assign xfer       = word_valid_i & word_ready_o;
  assign chain_full = cnt_q == CNT_LAST;
  assign last_bit   = chain_full || idx_q == IDX_LAST;

`ifdef CONFIG_LOADER_CRC_EN
  localparam state_e FULL_NEXT = CHECK;
  logic [7:0] crc;
  config_crc8 u_crc (
    .clock_i    (clock_i),
    .nreset_i   (nreset_i),
    .clear_i    (state_q == CLEAR),
    .bit_valid_i(config_enable_o),
    .bit_i      (sh_q[0]),
    .crc_o      (crc)
  );
  assign crc_ok = word_data_i[7:0] == crc;
`else
  localparam state_e FULL_NEXT = DONE;
  assign crc_ok = 1'b0;
`endif

  always_ff @(posedge clock_i)
    if (!nreset_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      clr_q           <= '0;
      sh_q            <= '0;
      config_nreset_q <= 1'b0;
      fabric_nreset_q <= 1'b0;
      fabric_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      clr_q           <= clr_d;
      sh_q            <= sh_d;
      config_nreset_q <= config_nreset_d;
      fabric_nreset_q <= fabric_nreset_d;
      fabric_enable_q <= fabric_enable_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_i) state_d = CLEAR;
      CLEAR:             if (clr_q == CLR_LAST) state_d = LOAD;
      LOAD:              if (xfer) state_d = SHIFT;
      SHIFT:             if (last_bit) state_d = chain_full ? FULL_NEXT : LOAD;
      CHECK:             if (xfer) state_d = crc_ok ? DONE : ERROR;
      default:           state_d = IDLE;
    endcase
  end

  // Bits past the chain end in the last word are dropped by leaving SHIFT early.
  always_comb begin
    clr_d = state_q == CLEAR ? clr_q + 1'b1 : '0;
    cnt_d = state_q == CLEAR ? '0 : state_q == SHIFT ? cnt_q + 1'b1 : cnt_q;
    idx_d = state_q == SHIFT ? idx_q + 1'b1 : '0;
    sh_d  = (state_q == LOAD && xfer) ? word_data_i : state_q == SHIFT ? sh_q >> 1 : sh_q;
  end

  // Fabric reset lifts on DONE entry; enable follows one cycle later.
  always_comb begin
    word_ready_o    = state_q == LOAD || state_q == CHECK;
    config_enable_o = state_q == SHIFT;
    config_out_o    = config_enable_o & sh_q[0];
    busy_o          = state_q inside {CLEAR, LOAD, SHIFT, CHECK};
    done_o          = state_q == DONE;
    error_o         = state_q == ERROR;
    config_nreset_d = state_d != CLEAR;
    fabric_nreset_d = state_d == DONE;
    fabric_enable_d = state_q == DONE && state_d == DONE;
  end

  assign config_nreset_o = config_nreset_q;
  assign fabric_nreset_o = fabric_nreset_q;
  assign fabric_enable_o = fabric_enable_q;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: randomized bitstream loads checked against a bit-queue reference
// model; defining CONFIG_LOADER_CRC_EN adds trailing-CRC good/bad cases.
module tb_config_loader;
  localparam int CL = 146, WW = 8, NW = (CL + WW - 1) / WW;
`ifdef CONFIG_LOADER_CRC_EN
  localparam int CRCW = 1;
`else
  localparam int CRCW = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nreset, start, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, config_out, config_enable, config_nreset;
  logic          fabric_nreset, fabric_enable, busy, done, error;

  config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .CLEAR_CYCLES(2)) dut (
    .clock_i(clk), .nreset_i(nreset), .start_i(start), .word_data_i(word_data),
    .word_valid_i(word_valid), .word_ready_o(word_ready), .config_out_o(config_out),
    .config_enable_o(config_enable), .config_nreset_o(config_nreset),
    .fabric_nreset_o(fabric_nreset), .fabric_enable_o(fabric_enable),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  logic       s_start, s_valid;
  logic [7:0] s_data;
  logic       s_ready, s_out, s_en, s_cnr, s_fnr, s_fen, s_busy, s_done, s_err;

  config_loader #(.CHAIN_LENGTH(8), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dut_s (
    .clock_i(clk), .nreset_i(nreset), .start_i(s_start), .word_data_i(s_data),
    .word_valid_i(s_valid), .word_ready_o(s_ready), .config_out_o(s_out),
    .config_enable_o(s_en), .config_nreset_o(s_cnr), .fabric_nreset_o(s_fnr),
    .fabric_enable_o(s_fen), .busy_o(s_busy), .done_o(s_done), .error_o(s_err)
  );

  int errors = 0, checks = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input bit b[$]);
    logic [7:0] c = 8'h00;
    foreach (b[i]) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  // Chain model: every enabled cycle appends one bit in shift order.
  bit         got_bits[$];
  int         accepted = 0, s_shifts = 0, s_acc = 0;
  bit         en_in_load = 1'b0;
  logic [7:0] s_got = 8'h00;
  always @(posedge clk) begin
    if (config_enable) got_bits.push_back(config_out);
    if (word_valid && word_ready) accepted++;
    if (config_enable && word_ready) en_in_load = 1'b1;
    if (s_en) begin
      s_got = {s_out, s_got[7:1]};
      s_shifts++;
    end
    if (s_valid && s_ready) s_acc++;
  end

  task automatic run_load(input int pct, input bit bad);
    logic [WW-1:0] words[$];
    bit            exp_bits[$];
    int            b0, a0, cyc, diff;
    for (int j = 0; j < NW; j++) words.push_back(WW'($urandom));
    for (int i = 0; i < CL; i++) exp_bits.push_back(words[i / WW][i % WW]);
    if (CRCW == 1) words.push_back(WW'(crc8(exp_bits) ^ {7'd0, bad}));
    b0 = got_bits.size();
    a0 = accepted;
    @(negedge clk);
    start = 1'b1;
    word_valid = 1'b1;
    word_data = words[0];
    @(negedge clk);
    start = 1'b0;
    check("clear_cfg_nreset_c1", config_nreset, 0);
    check("clear_fabric_c1", {fabric_nreset, fabric_enable}, 0);
    check("clear_busy", busy, 1);
    @(negedge clk);
    check("clear_cfg_nreset_c2", config_nreset, 0);
    cyc = 0;
    while (!done && !error && cyc < 3000) begin
      if (cyc == 1) check("load_cfg_nreset", config_nreset, 1);
      word_valid = (accepted - a0 < words.size()) && ($urandom_range(99) < pct);
      word_data  = word_valid ? words[accepted - a0] : WW'($urandom);
      start      = $urandom_range(15) == 0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    word_valid = 1'b0;
    check("load_finished", cyc < 3000, 1);
    diff = 0;
    for (int i = 0; i < CL; i++)
      if (b0 + i >= got_bits.size() || got_bits[b0 + i] != exp_bits[i]) diff++;
    check("chain_bit_diffs", diff, 0);
    check("shift_cycles", got_bits.size() - b0, CL);
    check("words_accepted", accepted - a0, words.size());
    check("done_error", {done, error}, bad ? 2'b01 : 2'b10);
    check("busy_at_end", busy, 0);
    check("fabric_nreset_entry", fabric_nreset, !bad);
    check("fabric_enable_entry", fabric_enable, 0);
    @(negedge clk);
    check("fabric_enable_next", fabric_enable, !bad);
    check("ready_after_end", word_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, a0, s0, sa;
    logic [7:0] wd, wcrc;
    bit         wb[$];
    nreset = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {word_ready, config_out, config_enable, config_nreset,
          fabric_nreset, fabric_enable, busy, done, error}, 0);
    nreset = 1'b1;
    @(negedge clk);
    check("idle_cfg_nreset", config_nreset, 1);
    check("idle_flags", {busy, word_ready, done, error}, 0);
    run_load(100, 1'b0);
    run_load(30, 1'b0);
    if (CRCW == 1) begin
      run_load(100, 1'b1);
      run_load(60, 1'b0);
    end
    // Abort after the seventh word has started shifting.
    a0 = accepted;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    word_valid = 1'b1;
    word_data = WW'($urandom);
    cyc = 0;
    while (accepted - a0 < 7 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    word_valid = 1'b0;
    check("mid_shift_reached", config_enable, 1);
    nreset = 1'b0;
    @(negedge clk);
    check("reset_mid_shift", {word_ready, config_out, config_enable, config_nreset,
          fabric_nreset, fabric_enable, busy, done, error}, 0);
    nreset = 1'b1;
    run_load(70, 1'b0);
    check("enable_in_load", en_in_load, 0);
    // Single-word chain, with a stray start while busy.
    wd = 8'($urandom);
    for (int i = 0; i < 8; i++) wb.push_back(wd[i]);
    wcrc = crc8(wb);
    s0 = s_shifts;
    sa = s_acc;
    @(negedge clk);
    s_start = 1'b1;
    s_valid = 1'b1;
    s_data = wd;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 0;
    while (!s_done && !s_err && cyc < 100) begin
      s_start = cyc == 4;
      s_data = (s_shifts - s0 >= 8) ? wcrc : wd;
      @(negedge clk);
      cyc++;
    end
    s_start = 1'b0;
    check("small_bits", s_got, wd);
    check("small_shifts", s_shifts - s0, 8);
    check("small_accepted", s_acc - sa, 1 + CRCW);
    check("small_done", {s_done, s_err, s_busy}, 3'b100);
    @(negedge clk);
    check("small_fabric", {s_fnr, s_fen, s_ready}, 3'b110);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
